// File: rtl/aes_pkg.sv
// Shared encodings and default widths for the AES mode controller.
// Mode and FSM state types live here so every unit agrees on them.
package aes_pkg;

  localparam int BLK_W_DEF = 128;
  localparam int CTR_W_DEF = 32;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    MODE_ECB = 2'd0,
    MODE_CBC = 2'd1,
    MODE_CTR = 2'd2,
    MODE_RSV = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_KLOAD   = 3'd1,
    ST_KWAIT   = 3'd2,
    ST_WAIT_IN = 3'd3,
    ST_ISSUE   = 3'd4,
    ST_RUN     = 3'd5,
    ST_OUT     = 3'd6
  } state_e;

endpackage

// File: rtl/aes_chain_unit.sv
// Combinational chaining logic: pre-XOR into the core, post-XOR of
// the core result and next value of the chain/counter register.
module aes_chain_unit
  import aes_pkg::*;
#(
  parameter int BLK_W = BLK_W_DEF,
  parameter int CTR_W = CTR_W_DEF
) (
  input  mode_e            mode_i,
  input  logic             dec_i,
  input  logic [BLK_W-1:0] x_i,
  input  logic [BLK_W-1:0] din_i,
  input  logic [BLK_W-1:0] core_out_i,
  output logic [BLK_W-1:0] core_in_o,
  output logic [BLK_W-1:0] result_o,
  output logic [BLK_W-1:0] x_next_o
);

  logic             is_ctr;
  logic             cbc_enc;
  logic             cbc_dec;
  logic [BLK_W-1:0] ctr_inc;

  assign is_ctr  = (mode_i == MODE_CTR);
  assign cbc_enc = (mode_i == MODE_CBC) && !dec_i;
  assign cbc_dec = (mode_i == MODE_CBC) && dec_i;

  // Counter bump wraps inside the low word; upper bits never carry.
  always_comb begin
    ctr_inc = x_i;
    ctr_inc[CTR_W-1:0] = x_i[CTR_W-1:0] + CTR_W'(1);
  end

  // Mode select: ECB (and reserved) passes straight through.
  always_comb begin
    core_in_o = din_i;
    result_o  = core_out_i;
    x_next_o  = x_i;
    unique case (1'b1)
      is_ctr: begin
        core_in_o = x_i;
        result_o  = core_out_i ^ din_i;
        x_next_o  = ctr_inc;
      end
      cbc_enc: begin
        core_in_o = din_i ^ x_i;
        x_next_o  = core_out_i;
      end
      cbc_dec: begin
        result_o = core_out_i ^ x_i;
        x_next_o = din_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/aes_mode_ctrl.sv
// Streaming ECB/CBC/CTR mode controller driving one external AES core.
// One block in flight: accept, issue, wait for core, present result.
module aes_mode_ctrl
  import aes_pkg::*;
#(
  parameter int BLK_W = BLK_W_DEF,
  parameter int CTR_W = CTR_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             dec,
  input  logic [BLK_W-1:0] key,
  input  logic [BLK_W-1:0] iv,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] blk_cnt,
  output logic             core_kld,
  output logic             core_ld,
  output logic             core_dec,
  output logic [BLK_W-1:0] core_key,
  output logic [BLK_W-1:0] core_text_in,
  input  logic             core_done,
  input  logic [BLK_W-1:0] core_text_out
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic             dec_q, dec_d;
  logic [BLK_W-1:0] key_q, key_d;
  logic [BLK_W-1:0] x_q, x_d;
  logic [BLK_W-1:0] in_q, in_d;
  logic             last_q, last_d;
  logic [BLK_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic [BLK_W-1:0] core_in;
  logic [BLK_W-1:0] result;
  logic [BLK_W-1:0] x_next;
  logic             is_ctr;
  mode_e            mode_in;

  assign is_ctr  = (mode_q == MODE_CTR);
  assign mode_in = (mode == MODE_RSV) ? MODE_ECB : mode_e'(mode);

  aes_chain_unit #(
    .BLK_W (BLK_W),
    .CTR_W (CTR_W)
  ) u_chain (
    .mode_i     (mode_q),
    .dec_i      (dec_q),
    .x_i        (x_q),
    .din_i      (in_q),
    .core_out_i (core_text_out),
    .core_in_o  (core_in),
    .result_o   (result),
    .x_next_o   (x_next)
  );

  assign in_ready     = (state_q == ST_WAIT_IN);
  assign out_valid    = (state_q == ST_OUT);
  assign out_data     = out_q;
  assign out_last     = last_q && (state_q == ST_OUT);
  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign blk_cnt      = cnt_q;
  assign core_kld     = (state_q == ST_KLOAD);
  assign core_ld      = (state_q == ST_ISSUE);
  assign core_dec     = dec_q && !is_ctr;
  assign core_key     = key_q;
  assign core_text_in = core_in;

  // Next-state and register-update logic for the message sequencer.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    dec_d   = dec_q;
    key_d   = key_q;
    x_d     = x_q;
    in_d    = in_q;
    last_d  = last_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d  = mode_in;
          dec_d   = dec;
          key_d   = key;
          x_d     = iv;
          cnt_d   = '0;
          state_d = ST_KLOAD;
        end
      end
      ST_KLOAD: begin
        if (dec_q && !is_ctr) state_d = ST_KWAIT;
        else                  state_d = ST_WAIT_IN;
      end
      ST_KWAIT: begin
        if (core_done) state_d = ST_WAIT_IN;
      end
      ST_WAIT_IN: begin
        if (in_valid) begin
          in_d    = in_data;
          last_d  = in_last;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (core_done) begin
          out_d   = result;
          x_d     = x_next;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (last_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT_IN;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any message in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_ECB;
      dec_q   <= 1'b0;
      key_q   <= '0;
      x_q     <= '0;
      in_q    <= '0;
      last_q  <= 1'b0;
      out_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      dec_q   <= dec_d;
      key_q   <= key_d;
      x_q     <= x_d;
      in_q    <= in_d;
      last_q  <= last_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: doc/aes_mode_ctrl.md
Name: aes_mode_ctrl

Overview:
- Streaming block-cipher mode controller for the AES engines.
- Accepts 128-bit blocks over a valid/ready stream and applies ECB, CBC or CTR chaining, encrypt or decrypt.
- Drives one external AES core through a load/done port (aes_cipher or aes_decipher, selected by core_dec) and returns results over a valid/ready stream.
- Replaces fixed single-vector wrappers with a configurable, multi-block, back-pressured datapath.

Parameters:
- BLK_W, 128, block/key/IV width (AES-128; held at 128).
- CTR_W, 32, CTR-mode counter width (low CTR_W bits of counter block).
- CNT_W, 16, width of the processed-block counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a message; sampled in IDLE only
- mode  in  2  0=ECB, 1=CBC, 2=CTR, 3=reserved (treated as ECB); latched at start
- dec  in  1  1=decrypt; latched at start; ignored in CTR
- key  in  BLK_W  cipher key; latched at start
- iv  in  BLK_W  CBC IV / CTR initial counter block; latched at start
- in_valid  in  1  input block valid
- in_ready  out  1  input block accepted when in_valid & in_ready
- in_data  in  BLK_W  input block
- in_last  in  1  marks final block of message
- out_valid  out  1  output block valid
- out_ready  in  1  downstream accepts
- out_data  out  BLK_W  result block
- out_last  out  1  final result of message
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse when the last block is handed off
- blk_cnt  out  CNT_W  blocks output since start; wraps mod 2^CNT_W
- core_kld  out  1  one-cycle key-load pulse
- core_ld  out  1  one-cycle block-load pulse
- core_dec  out  1  selects decipher engine
- core_key  out  BLK_W  latched key
- core_text_in  out  BLK_W  block to core, valid with core_ld
- core_done  in  1  core result / key-schedule ready pulse
- core_text_out  in  BLK_W  core result, valid with core_done

Behaviour:
- Reset values: all outputs 0; state IDLE; chain, counter, key and output registers cleared.
- rst mid-message aborts immediately. No partial output is emitted, and core_done arriving after reset is ignored.
- States and transitions:
  - IDLE: on start, latch mode/dec/key/iv, clear blk_cnt, go to KLOAD.
  - KLOAD: core_kld=1 for one cycle.
    - Decrypt with a non-CTR mode goes to KWAIT.
    - All other cases go to WAIT_IN.
  - KWAIT: wait for core_done (key schedule ready), then go to WAIT_IN.
  - WAIT_IN: in_ready=1. On handshake, capture in_data and in_last, then go to ISSUE.
  - ISSUE: core_ld=1 for one cycle with core_text_in driven, then go to RUN.
  - RUN: wait for core_done. Compute the result into the output register, update chain/counter, go to OUT.
  - OUT: out_valid=1, data held stable until out_ready.
    - On handshake, blk_cnt += 1.
    - If last: pulse done next cycle and go to IDLE.
    - Otherwise go to WAIT_IN.
- Datapath (P = plaintext, C = ciphertext, X = chain register initialised to iv):
  - ECB: core_in = in_data; out = core_out.
  - CBC enc: core_in = P ^ X; out = core_out; X <= core_out.
  - CBC dec: core_in = C; out = core_out ^ X; X <= C (captured input).
  - CTR (both directions): core_dec=0; core_in = X; out = core_out ^ in_data.
    - X[CTR_W-1:0] += 1, wrapping with no carry into the upper bits.
    - Upper bits stay unchanged.
- core_dec = dec & (mode != CTR), held for the whole message.
- Single outstanding block; no overlap.
  - Throughput: one block per (core latency + 3) cycles, assuming out_ready is held high.
- core_done outside KWAIT/RUN is ignored.
- start while busy is ignored.
- Input gaps (in_valid low) stall in WAIT_IN indefinitely; chain state is preserved.

Decomposition:
- Shared package aes_pkg holds:
  - mode encodings MODE_ECB/CBC/CTR
  - state encodings
  - BLK_W default
- One natural sub-module: aes_chain_unit, the combinational pre-/post-XOR and counter-increment logic selected by mode and dec. The FSM and registers stay in aes_mode_ctrl.

Test Plan:
- ECB enc: key 2b7e151628aed2a6abf7158809cf4f3c, P 3243f6a8885a308d313198a2e0370734, single in_last block. Expect out_data 3925841d02dc09fbdc118597196a0b32, out_last=1, done pulse, blk_cnt=1.
- ECB dec of that ciphertext, same key. Expect KWAIT entered, then 3243f6a8885a308d313198a2e0370734.
- CBC enc, iv=0, 3 blocks, random out_ready back-pressure.
  - Block 0 must equal the ECB result.
  - Blocks 1..2 must match the software model.
  - CBC dec of the output must return the original plaintext.
- CTR with iv low word ffffffff, 2 blocks. Expect the second counter block to have low word 00000000 with upper 96 bits unchanged, and core_dec=0 while dec=1.
- Assert rst during RUN. Next cycle all outputs are 0 and the state is IDLE; a late core_done produces no out_valid; a fresh start works.
- Pulse start while busy, and drive core_done in WAIT_IN. Both are ignored; blk_cnt wraps from ffff to 0000 over a long message.
